// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: loader port in IDLE, sequential fetch into the IF/ID register in RUN.
// Define FETCH_CTRL_PERF_EN to build the fetch/stall performance counters.
module fetch_ctrl #(
    parameter logic [31:0] BOOT_PC     = 32'h00000000,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        load_valid,
    input  logic [8:0]  load_addr,
    input  logic [31:0] load_data,
    output logic        load_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    output logic        imem_we,
    output logic [31:0] imem_wdata,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [1:0]  state,
    output logic        fault,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10,
        BAD  = 2'b11
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] pc4_s;
    logic        in_range_s;
    logic        is_halt_s;

    assign pc4_s      = pc_r + 32'd4;
    // Only the 512-word instruction memory is fetchable.
    assign in_range_s = (pc_r[31:11] == 21'd0);
    assign is_halt_s  = (imem_rdata[31:26] == HALT_OPCODE);
    assign state      = state_r;

    // Memory port mux: loader owns the memory in IDLE, the PC drives it otherwise.
    always_comb begin
        load_ready = 1'b0;
        imem_we    = 1'b0;
        imem_addr  = {2'b00, pc_r[31:2]};
        imem_wdata = load_data;
        if (rst) begin
            load_ready = 1'b0;
            imem_we    = 1'b0;
        end else if (state_r == IDLE) begin
            load_ready = 1'b1;
            imem_we    = load_valid;
            imem_addr  = {23'd0, load_addr};
        end else begin
            load_ready = 1'b0;
            imem_we    = 1'b0;
        end
    end

    // Control FSM, program counter and IF/ID register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            pc_r        <= BOOT_PC;
            if_id_inst  <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if_id_valid <= 1'b0;
                    if (start && !load_valid) begin
                        state_r <= RUN;
                        pc_r    <= BOOT_PC;
                    end
                end
                RUN: begin
                    if (branch_taken) begin
                        pc_r        <= branch_target;
                        if_id_valid <= 1'b0;
                    end else if (!in_range_s) begin
                        fault       <= 1'b1;
                        if_id_valid <= 1'b0;
                        state_r     <= HALT;
                    end else if (!stall) begin
                        if_id_inst  <= imem_rdata;
                        if_id_pc4   <= pc4_s;
                        if_id_valid <= 1'b1;
                        // A halt instruction is delivered, but the PC stays on it.
                        if (is_halt_s) begin
                            state_r <= HALT;
                        end else begin
                            pc_r <= pc4_s;
                        end
                    end
                end
                HALT: begin
                    if_id_valid <= 1'b0;
                    if (start) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    if_id_valid <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] fetch_count_r;
    logic [31:0] stall_count_r;
    logic        fetch_s;
    logic        stall_cnt_s;

    assign fetch_s     = (state_r == RUN) && !branch_taken && in_range_s && !stall;
    assign stall_cnt_s = (state_r == RUN) && !branch_taken && stall;

    // Free-running performance counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_r <= 32'd0;
            stall_count_r <= 32'd0;
        end else begin
            if (fetch_s) begin
                fetch_count_r <= fetch_count_r + 32'd1;
            end
            if (stall_cnt_s) begin
                stall_count_r <= stall_count_r + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_count_r;
    assign stall_count = stall_count_r;
`else
    assign fetch_count = 32'h0;
    assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random traffic
// against a behavioural model with its own shadow copy of instruction memory.
module tb_fetch_ctrl;

    localparam logic [31:0] BOOT = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        load_valid = 1'b0;
    logic [8:0]  load_addr = 9'd0;
    logic [31:0] load_data = 32'd0;
    logic        load_ready;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] imem_addr;
    logic        imem_we;
    logic [31:0] imem_wdata;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [1:0]  state;
    logic        fault;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    always #5 clk = ~clk;

    fetch_ctrl #(.BOOT_PC(BOOT), .HALT_OPCODE(6'h3F)) dut (
        .clk(clk), .rst(rst), .start(start),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .load_ready(load_ready), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_we(imem_we),
        .imem_wdata(imem_wdata), .imem_rdata(imem_rdata), .if_id_inst(if_id_inst),
        .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .state(state),
        .fault(fault), .fetch_count(fetch_count), .stall_count(stall_count)
    );

    // Instruction memory with combinational read.
    logic [31:0] mem [0:511];
    always @(posedge clk) begin
        if (imem_we) mem[imem_addr[8:0]] <= imem_wdata;
    end
    assign imem_rdata = (imem_addr < 32'd512) ? mem[imem_addr[8:0]] : 32'h0;

    // Reference model state.
    int          m_state;
    logic [31:0] m_pc, m_inst, m_pc4, m_fc, m_sc;
    logic        m_valid, m_fault;
    logic [31:0] ref_mem [0:511];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_word(input logic allow_halt);
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'h3F) w[31] = 1'b0;
        if (allow_halt && ($urandom_range(0, 7) == 0)) w[31:26] = 6'h3F;
        return w;
    endfunction

    task automatic model_reset();
        m_state = 0; m_pc = BOOT; m_inst = 32'd0; m_pc4 = 32'd0;
        m_valid = 1'b0; m_fault = 1'b0; m_fc = 32'd0; m_sc = 32'd0;
    endtask

    task automatic model_next(input logic st, input logic lv, input logic [8:0] la,
                              input logic [31:0] ld, input logic stl, input logic bt,
                              input logic [31:0] btg);
        logic [31:0] word;
        case (m_state)
            0: begin
                if (lv) ref_mem[la] = ld;
                else if (st) begin m_state = 1; m_pc = BOOT; end
            end
            1: begin
                if (bt) begin
                    m_pc = btg; m_valid = 1'b0;
                end else begin
                    if (stl) m_sc = m_sc + 32'd1;
                    if (m_pc >= 32'd2048) begin
                        m_fault = 1'b1; m_valid = 1'b0; m_state = 2;
                    end else if (!stl) begin
                        word = ref_mem[m_pc[10:2]];
                        m_inst = word; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                        m_fc = m_fc + 32'd1;
                        if (word[31:26] == 6'h3F) m_state = 2;
                        else m_pc = m_pc + 32'd4;
                    end
                end
            end
            default: begin
                m_valid = 1'b0;
                if (st) m_state = 0;
            end
        endcase
    endtask

    task automatic check_regs();
        chk("state", {30'd0, state}, m_state[31:0]);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        chk("fault", {31'd0, fault}, {31'd0, m_fault});
        if (m_valid) begin
            chk("if_id_inst", if_id_inst, m_inst);
            chk("if_id_pc4", if_id_pc4, m_pc4);
        end
`ifdef FETCH_CTRL_PERF_EN
        chk("fetch_count", fetch_count, m_fc);
        chk("stall_count", stall_count, m_sc);
`else
        chk("fetch_count", fetch_count, 32'd0);
        chk("stall_count", stall_count, 32'd0);
`endif
    endtask

    // One clock: drive inputs, check the memory port, advance the model, check registers.
    task automatic step(input logic st, input logic lv, input logic [8:0] la,
                        input logic [31:0] ld, input logic stl, input logic bt,
                        input logic [31:0] btg);
        start = st; load_valid = lv; load_addr = la; load_data = ld;
        stall = stl; branch_taken = bt; branch_target = btg;
        #1;
        if (m_state == 0) begin
            chk("load_ready", {31'd0, load_ready}, 32'd1);
            chk("imem_we", {31'd0, imem_we}, {31'd0, lv});
            chk("imem_addr_load", imem_addr, {23'd0, la});
            chk("imem_wdata", imem_wdata, ld);
        end else begin
            chk("load_ready", {31'd0, load_ready}, 32'd0);
            chk("imem_we", {31'd0, imem_we}, 32'd0);
            chk("imem_addr_pc", imem_addr, m_pc >> 2);
        end
        model_next(st, lv, la, ld, stl, bt, btg);
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        load_valid = 1'b1; load_addr = 9'd5; load_data = 32'hDEAD_BEEF;
        #1;
        chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        @(posedge clk);
        #1;
        model_reset();
        check_regs();
        chk("rst_inst", if_id_inst, 32'd0);
        chk("rst_pc4", if_id_pc4, 32'd0);
        rst = 1'b0; load_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Fill the whole memory with non-halt words.
        for (int i = 0; i < 512; i++) begin
            w = rand_word(1'b0);
            step(1'b0, 1'b1, i[8:0], w, 1'b0, 1'b0, 32'd0);
        end

        // START together with a load: write wins, stay IDLE.
        step(1'b1, 1'b1, 9'd3, 32'h0000_1234, 1'b0, 1'b0, 32'd0);
        chk("start_with_load", {30'd0, state}, 32'd0);

        // Boot and fetch two words, stall three cycles at PC=8, fetch two more.
        step(1'b1, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("run_entry", {30'd0, state}, 32'd1);
        step(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("pc4_first", if_id_pc4, 32'd4);
        step(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("pc4_second", if_id_pc4, 32'd8);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0, 32'd0);
            chk("stall_hold_pc4", if_id_pc4, 32'd8);
            chk("stall_hold_addr", imem_addr, 32'd2);
        end
        step(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("pc4_third", if_id_pc4, 32'd12);
        step(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("pc4_fourth", if_id_pc4, 32'd16);

        // Branch beats stall.
        step(1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b1, 32'h40);
        chk("branch_flush", {31'd0, if_id_valid}, 32'd0);
        chk("branch_addr", imem_addr, 32'd16);
        step(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("branch_pc4", if_id_pc4, 32'h44);
        step(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 32'd0);

        // Reset mid-run, then halt on word 2.
        do_reset();
        step(1'b0, 1'b1, 9'd2, 32'hFC00_0000, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("halt_state", {30'd0, state}, 32'd2);
        chk("halt_valid", {31'd0, if_id_valid}, 32'd1);
        chk("halt_inst", if_id_inst, 32'hFC00_0000);
        step(1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b1, 32'h100);
        chk("halt_drop_valid", {31'd0, if_id_valid}, 32'd0);
        chk("halt_pc_frozen", imem_addr, 32'd2);
        step(1'b1, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("halt_to_idle", {30'd0, state}, 32'd0);

        // Branch out of range -> fault.
        step(1'b1, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b1, 32'h800);
        step(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("fault_set", {31'd0, fault}, 32'd1);
        chk("fault_state", {30'd0, state}, 32'd2);
        chk("fault_no_valid", {31'd0, if_id_valid}, 32'd0);
        step(1'b1, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("fault_sticky", {31'd0, fault}, 32'd1);
        step(1'b1, 1'b1, 9'd7, 32'h0BAD_F00D, 1'b0, 1'b0, 32'd0);
        chk("idle_load_start", {30'd0, state}, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            if ($urandom_range(0, 19) == 0) tgt = 32'h800 + ($urandom_range(0, 63) << 2);
            else tgt = $urandom_range(0, 127) << 2;
            step($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                 9'($urandom_range(0, 511)), rand_word(1'b1),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, tgt);
        end

        do_reset();
        chk("final_fault_clear", {31'd0, fault}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
